uart_tx_fifo: RTL and testbench

Byte buffer sitting directly upstream of `uart_transmitter`. It accepts bytes from a producer over a valid/ready handshake, stores up to `DEPTH` of them, and feeds them one at a time to the transmitter through its `data_in`/`send`/`busy` interface. This decouples bursty producers, such as a command parser or a test-pattern generator, from the slow serial line.

---
 rtl/uart_tx_fifo.sv | 149 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding uart_transmitter via data_in/send/busy.
// Optional UART_TX_FIFO_OVERFLOW_EN adds sticky overflow flag and saturating drop counter.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_send,
  input  logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
`ifdef UART_TX_FIFO_OVERFLOW_EN
  ,
  output logic                     overflow,
  output logic [7:0]               drop_count
`else
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  logic [7:0]    mem [DEPTH];
  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_send_q, tx_send_d;
  logic          push, launch;

  assign full     = (count_q == LW'(DEPTH));
  assign empty    = (count_q == '0);
  assign wr_ready = !full;
  assign level    = count_q;
  assign tx_data  = tx_data_q;
  assign tx_send  = tx_send_q;
  assign push     = wr_valid && !full;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    timer_d   = timer_q;
    tx_data_d = tx_data_q;
    tx_send_d = 1'b0;
    launch    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty && !tx_busy) launch = 1'b1;
      end
      WAIT_BUSY: begin
        // A timed-out byte is treated as sent; it is never relaunched.
        if (tx_busy) state_d = WAIT_DONE;
        else if (timer_q == '0) state_d = IDLE;
        else timer_d = timer_q - TW'(1);
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (!empty) launch = 1'b1;
          else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      tx_data_d = mem[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + AW'(1);
      tx_send_d = 1'b1;
      timer_d   = TW'(BUSY_TIMEOUT - 1);
      state_d   = WAIT_BUSY;
    end

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);

    case ({push, launch})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      tx_data_q <= 8'h00;
      tx_send_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      tx_data_q <= tx_data_d;
      tx_send_q <= tx_send_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic       overflow_q, overflow_d;
  logic [7:0] drop_count_q, drop_count_d;
  logic       drop;

  assign drop       = wr_valid && full;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

  always_comb begin
    overflow_d   = overflow_q | drop;
    drop_count_d = drop_count_q;
    if (drop && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q   <= 1'b0;
      drop_count_q <= 8'h00;
    end else begin
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end
`else
  // Writes while full are dropped silently.
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy;
  logic [4:0] level;
  logic       empty;
  logic       full;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic       overflow;
  logic [7:0] drop_count;
`endif

  logic force_busy = 1'b0;
  logic model_en   = 1'b0;
  logic model_busy = 1'b0;
  assign tx_busy = model_en ? model_busy : force_busy;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  int cyc = 0;
  int busy_len = 20;
  int busy_cnt = 0;
  int fall_cyc = 0;
  int last_send_cyc = 0;
  int prev_send_cyc = 0;
  int n_sends = 0;
  int max_level = 0;
  logic send_seen = 1'b0;
  logic prev_send = 1'b0;
  logic gap_chk = 1'b0;

  uart_tx_fifo #(.DEPTH(DEPTH), .BUSY_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .level(level), .empty(empty), .full(full)
`ifdef UART_TX_FIFO_OVERFLOW_EN
    , .overflow(overflow), .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transmitter model: samples tx_send at an edge, then stays busy for busy_len clocks.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      model_busy = 1'b0;
      busy_cnt = 0;
    end else begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          model_busy = 1'b0;
          fall_cyc = cyc;
        end
      end
      if (model_en && send_seen) begin
        model_busy = 1'b1;
        busy_cnt = busy_len;
      end
    end
  end

  // Monitor: pops the scoreboard on every tx_send pulse.
  initial forever begin
    logic [7:0] e;
    @(negedge clk);
    send_seen = tx_send;
    if (int'(level) > max_level) max_level = int'(level);
    if (tx_send) begin
      chk("send_width_one_cycle", {31'd0, prev_send}, 32'd0);
      chk("sb_queue_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tx_data_order", {24'd0, tx_data}, {24'd0, e});
      end
      if (gap_chk && fall_cyc > last_send_cyc)
        chk("send_one_clk_after_busy_fall", cyc, fall_cyc + 1);
      prev_send_cyc = last_send_cyc;
      last_send_cyc = cyc;
      n_sends++;
    end
    prev_send = tx_send;
  end

  // Called at a negedge; returns at the next negedge.
  task automatic push(input logic [7:0] b, input bit accepted);
    wr_data = b;
    wr_valid = 1'b1;
    if (accepted) exp_q.push_back(b);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [7:0] b);
    int t = 0;
    while (!wr_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("push_wait_bound", {31'd0, wr_ready}, 32'd1);
    push(b, wr_ready);
  endtask

  task automatic wait_drain(input int max);
    int t = 0;
    while (exp_q.size() != 0 && t < max) begin
      @(negedge clk);
      t++;
    end
    chk("drain_bound", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_tx_send", {31'd0, tx_send}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_drop_count", {24'd0, drop_count}, 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // Single byte: level=1 after E0, pulse after E1, level back to 0.
    force_busy = 1'b0;
    push(8'hA5, 1);
    chk("single_level_after_push", {27'd0, level}, 32'd1);
    chk("single_no_send_yet", {31'd0, tx_send}, 32'd0);
    @(negedge clk);
    chk("single_send_after_e1", {31'd0, tx_send}, 32'd1);
    chk("single_tx_data", {24'd0, tx_data}, 32'hA5);
    chk("single_level_zero", {27'd0, level}, 32'd0);
    @(negedge clk);
    chk("single_send_dropped", {31'd0, tx_send}, 32'd0);
    chk("single_tx_data_hold", {24'd0, tx_data}, 32'hA5);
    repeat (8) @(negedge clk);

    // Busy timeout: busy never rises, next launch 5 edges later (4 clocks of wait).
    s = n_sends;
    push(8'h3C, 1);
    push(8'h3D, 1);
    wait_drain(50);
    chk("timeout_gap", last_send_cyc - prev_send_cyc, 5);
    repeat (12) @(negedge clk);
    chk("timeout_no_repeat", n_sends, s + 2);
    chk("timeout_level", {27'd0, level}, 32'd0);

    // Fill and overflow with the transmitter held busy.
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(8'h10 + 8'(i), 1);
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("fill_level", {27'd0, level}, 32'd16);
    push(8'hEE, 0);
    chk("fill_level_after_drop", {27'd0, level}, 32'd16);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    chk("fill_overflow", {31'd0, overflow}, 32'd1);
    chk("fill_drop_count", {24'd0, drop_count}, 32'd1);
`endif
    force_busy = 1'b0;
    wait_drain(200);
    chk("fill_drained_empty", {31'd0, empty}, 32'd1);
    repeat (8) @(negedge clk);

    // Burst order with a 20-clock transmitter.
    model_en = 1'b1;
    busy_len = 20;
    gap_chk = 1'b1;
    s = n_sends;
    for (int i = 1; i <= 5; i++) push(8'(i), 1);
    wait_drain(300);
    gap_chk = 1'b0;
    chk("burst_send_count", n_sends, s + 5);
    repeat (25) @(negedge clk);

    // Wrap-around: 40 bytes with producer flow control.
    busy_len = 2;
    max_level = 0;
    for (int i = 0; i < 40; i++) push_wait(8'(i));
    wait_drain(600);
    chk("wrap_level_le_depth", {31'd0, max_level <= DEPTH}, 32'd1);
    chk("wrap_empty", {31'd0, empty}, 32'd1);
    repeat (8) @(negedge clk);

    // Reset mid-burst while in WAIT_DONE with three bytes queued.
    busy_len = 20;
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), 1);
    chk("midrst_pre_level", {27'd0, level}, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_level", {27'd0, level}, 32'd0);
    chk("midrst_empty", {31'd0, empty}, 32'd1);
    chk("midrst_tx_send", {31'd0, tx_send}, 32'd0);
    chk("midrst_wr_ready", {31'd0, wr_ready}, 32'd1);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    chk("midrst_overflow_cleared", {31'd0, overflow}, 32'd0);
`endif
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    s = n_sends;
    repeat (30) @(negedge clk);
    chk("midrst_no_send_after_release", n_sends, s);
    push(8'h5A, 1);
    wait_drain(40);
    chk("midrst_new_push_sent", n_sends, s + 1);
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
